// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: stream framing constants,
// FSM state encodings and the header acceptance check.
package loader_pkg;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CNT_W          = HDR_BYTES * 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LEN_LO = 3'd1;
  localparam state_t ST_LEN_HI = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_DONE   = 3'd4;
  localparam state_t ST_ERROR  = 3'd5;

  // A program must hold at least one word and fit in instruction memory.
  function automatic logic hdr_ok(input logic [CNT_W-1:0] n,
                                  input int unsigned      max_words);
    return (n != '0) && (32'(n) <= max_words);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian 32-bit words from a byte stream and flags each
// completed word for exactly one cycle.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_accept,
  input  logic [7:0]  in_data,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [31:0]      shift_q, shift_d;
  logic             word_valid_q, word_valid_d;

  assign last_byte  = (byte_idx_q == IDX_W'(BYTES_PER_WORD - 1));
  assign word_valid = word_valid_q;
  assign word       = shift_q;

  // Shift new bytes in from the top so the first byte ends up in [7:0].
  always_comb begin
    byte_idx_d   = byte_idx_q;
    shift_d      = shift_q;
    word_valid_d = 1'b0;
    if (clear) begin
      byte_idx_d = '0;
    end else if (in_accept) begin
      shift_d      = {in_data, shift_q[31:8]};
      byte_idx_d   = byte_idx_q + 1'b1;
      word_valid_d = last_byte;
    end
  end

  // Packer state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_idx_q   <= '0;
      shift_q      <= '0;
      word_valid_q <= 1'b0;
    end else begin
      byte_idx_q   <= byte_idx_d;
      shift_q      <= shift_d;
      word_valid_q <= word_valid_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed byte stream into instruction memory, holding the
// CPU in reset until the final word has been written.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MAX_WORDS  = 2 ** ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  state_t                state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  accept;
  logic                  pk_clear;
  logic                  pk_last;
  logic                  pk_valid;
  logic [31:0]           pk_word;
  logic [CNT_W-1:0]      hdr_len;

  assign in_ready  = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                     (state_q == ST_DATA);
  assign accept    = in_valid && in_ready;
  assign hdr_len   = {in_data, len_lo_q};

  assign mem_we    = pk_valid;
  assign mem_wdata = pk_word;
  assign mem_addr  = mem_addr_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

  byte_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (pk_clear),
    .in_accept  (accept && (state_q == ST_DATA)),
    .in_data    (in_data),
    .last_byte  (pk_last),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  // Session FSM: header capture, word counting and output flags.
  // The write address is latched together with the 4th byte so it is stable
  // during the mem_we pulse and never shows the post-increment count.
  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    mem_addr_d = mem_addr_q;
    pk_clear   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_lo_d = in_data;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d = hdr_len;
          if (hdr_ok(hdr_len, MAX_WORDS)) begin
            state_d    = ST_DATA;
            word_cnt_d = '0;
            mem_addr_d = '0;
            pk_clear   = 1'b1;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_DATA: begin
        if (accept && pk_last) begin
          mem_addr_d = ADDR_WIDTH'(word_cnt_q);
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (word_cnt_q == len_q - CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (start) state_d = ST_LEN_LO;
      end
      default: state_d = ST_IDLE;
    endcase

    cpu_reset_d = (state_d != ST_DONE);
    done_d      = (state_d == ST_DONE);
    error_d     = (state_d == ST_ERROR);
  end

  // Loader state registers; reset parks the CPU in reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_lo_q    <= '0;
      len_q       <= '0;
      word_cnt_q  <= '0;
      mem_addr_q  <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      mem_addr_q  <= mem_addr_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

endmodule
